// File: rtl/water_level_encoder.sv
// water_level_encoder
//
// Front end of the tank water-level display path. The three float switches
// are synchronized, debounced and checked for a legal fill pattern. The
// result is a registered 2-bit level code for the downstream 7-segment level
// decoder, plus a sticky sensor-fault indication and a hysteresis pump
// request.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable-sample count before a sensor vector is accepted (>= 2)
//   FAULT_CYCLES     tolerance for an illegal accepted vector before FAULT (>= 1)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   SensorLow   in   low float switch (async), 1 = water present
//   SensorMid   in   mid float switch (async), 1 = water present
//   SensorHigh  in   high float switch (async), 1 = water present
//   ClearFault  in   synchronous fault-clear request, level-sampled
//   Bit1        out  level code bit 1
//   Bit0        out  level code bit 0
//   Valid       out  Bit1/Bit0 reflect a current, legal, debounced level
//   Fault       out  sticky sensor-fault indication
//   PumpOn      out  pump request
//
// Level code (Bit1, Bit0) from accepted vector {High, Mid, Low}:
//   000 -> 00 (empty, blank), 001 -> 10, 011 -> 01, 111 -> 11; all else illegal.

module water_level_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FAULT_CYCLES    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SensorLow,
    input  logic SensorMid,
    input  logic SensorHigh,
    input  logic ClearFault,
    output logic Bit1,
    output logic Bit0,
    output logic Valid,
    output logic Fault,
    output logic PumpOn
);

    localparam int unsigned NW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned FW = $clog2(FAULT_CYCLES + 1);

    localparam logic [NW-1:0] N_MAX   = NW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] F_LIMIT = FW'(FAULT_CYCLES);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_SUSPECT,
        ST_FAULT
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_legal(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
    endfunction

    function automatic logic [1:0] encode(input logic [2:0] v);
        logic [1:0] c;
        c = 2'b00;
        case (v)
            3'b001:  c = 2'b10;
            3'b011:  c = 2'b01;
            3'b111:  c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    logic [2:0] sync_q1;
    logic [2:0] sync_q2;
    // Shift-in of ones marking when sync_q2 holds a real post-reset sample.
    logic [1:0] sync_fill;
    logic       samp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            sync_fill <= '0;
        end else begin
            sync_q1   <= {SensorHigh, SensorMid, SensorLow};
            sync_q2   <= sync_q1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign samp_valid = sync_fill[1];

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [2:0]    cand;
    logic [NW-1:0] cnt;
    logic          cand_loaded;
    logic [2:0]    acc_vec;
    logic          accept;
    logic [2:0]    a_next;

    // The candidate is only loaded from genuine post-reset samples, so the
    // reset value of the synchronizer is never mistaken for a stable input;
    // this gives reset release the same latency as any sensor change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand        <= '0;
            cnt         <= '0;
            cand_loaded <= 1'b0;
            acc_vec     <= '0;
        end else if (samp_valid) begin
            if (!cand_loaded || (sync_q2 != cand)) begin
                cand        <= sync_q2;
                cnt         <= '0;
                cand_loaded <= 1'b1;
            end else if (cnt != N_MAX) begin
                cnt <= cnt + NW'(1);
            end else begin
                acc_vec <= cand;
            end
        end
    end

    assign accept = samp_valid && cand_loaded && (sync_q2 == cand) && (cnt == N_MAX);

    // Value the accepted vector takes after this edge; the FSM acts on it so
    // outputs update on the same edge as the accept event.
    assign a_next = accept ? cand : acc_vec;

    // ------------------------------------------------------------------
    // Level FSM with registered outputs
    // ------------------------------------------------------------------
    state_t        state;
    logic [FW-1:0] fcnt;
    logic          legal_next;
    logic [1:0]    code_next;
    logic          pump_next;

    assign legal_next = is_legal(a_next);
    assign code_next  = encode(a_next);

    // Hysteresis: run when empty, stop when full, otherwise keep request.
    always_comb begin
        pump_next = PumpOn;
        if (a_next == 3'b000) begin
            pump_next = 1'b1;
        end else if (a_next == 3'b111) begin
            pump_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_NORMAL;
            fcnt   <= '0;
            Bit1   <= 1'b0;
            Bit0   <= 1'b0;
            Valid  <= 1'b0;
            Fault  <= 1'b0;
            PumpOn <= 1'b0;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (accept) begin
                        if (legal_next) begin
                            Bit1   <= code_next[1];
                            Bit0   <= code_next[0];
                            Valid  <= 1'b1;
                            PumpOn <= pump_next;
                        end else begin
                            state <= ST_SUSPECT;
                            fcnt  <= '0;
                            Valid <= 1'b0;
                        end
                    end
                end

                ST_SUSPECT: begin
                    // A legal accept wins over the fault timeout on the same edge.
                    if (legal_next) begin
                        state  <= ST_NORMAL;
                        Bit1   <= code_next[1];
                        Bit0   <= code_next[0];
                        Valid  <= 1'b1;
                        PumpOn <= pump_next;
                    end else if (fcnt == F_LIMIT) begin
                        state  <= ST_FAULT;
                        Fault  <= 1'b1;
                        Bit1   <= 1'b0;
                        Bit0   <= 1'b0;
                        Valid  <= 1'b0;
                        PumpOn <= 1'b0;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end

                ST_FAULT: begin
                    if (ClearFault && legal_next) begin
                        state  <= ST_NORMAL;
                        Fault  <= 1'b0;
                        Bit1   <= code_next[1];
                        Bit0   <= code_next[0];
                        Valid  <= 1'b1;
                        PumpOn <= pump_next;
                    end
                end

                default: begin
                    state <= ST_NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_level_encoder.sv
// Testbench for water_level_encoder: directed scenarios plus randomized
// sensor sequences, all checked against a behavioural reference model.

module tb_water_level_encoder;

    localparam int DC = 4;
    localparam int FC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SensorLow = 1'b0;
    logic SensorMid = 1'b0;
    logic SensorHigh = 1'b0;
    logic ClearFault = 1'b0;
    logic Bit1, Bit0, Valid, Fault, PumpOn;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    water_level_encoder #(
        .DEBOUNCE_CYCLES(DC),
        .FAULT_CYCLES   (FC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SensorLow (SensorLow),
        .SensorMid (SensorMid),
        .SensorHigh(SensorHigh),
        .ClearFault(ClearFault),
        .Bit1      (Bit1),
        .Bit0      (Bit0),
        .Valid     (Valid),
        .Fault     (Fault),
        .PumpOn    (PumpOn)
    );

    // ------------------------------------------------------------------
    // Reference model: a vector is accepted on edge t when the raw samples
    // taken on edges t-2-DC .. t-2 (since reset release) are all equal.
    // ------------------------------------------------------------------
    logic [2:0] hist[$];
    int         m_mode;      // 0 normal, 1 suspect, 2 fault
    int         m_age;       // edges spent in suspect
    logic [2:0] m_a;
    logic [1:0] m_code;
    logic       m_valid, m_fault, m_pump;

    function automatic logic legal(input logic [2:0] v);
        return (v == 3'd0) || (v == 3'd1) || (v == 3'd3) || (v == 3'd7);
    endfunction

    function automatic logic [1:0] code_of(input logic [2:0] v);
        if (v == 3'd1) return 2'b10;
        if (v == 3'd3) return 2'b01;
        if (v == 3'd7) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [4:0] dut_vec();
        return {Bit1, Bit0, Valid, Fault, PumpOn};
    endfunction

    function automatic logic [4:0] exp_vec();
        return {m_code, m_valid, m_fault, m_pump};
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode  = 0;
        m_age   = 0;
        m_a     = 3'd0;
        m_code  = 2'b00;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_pump  = 1'b0;
    endtask

    task automatic model_load(input logic [2:0] v);
        m_code  = code_of(v);
        m_valid = 1'b1;
        if (v == 3'd0) m_pump = 1'b1;
        if (v == 3'd7) m_pump = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] s, input logic clr);
        bit         acc;
        logic [2:0] an;
        int         n;
        hist.push_back(s);
        while (hist.size() > DC + 3) void'(hist.pop_front());
        n   = hist.size();
        acc = 1'b0;
        if (n >= DC + 3) begin
            acc = 1'b1;
            for (int i = n - 3 - DC; i <= n - 3; i++)
                if (hist[i] !== hist[n-3]) acc = 1'b0;
        end
        an  = acc ? hist[n-3] : m_a;
        m_a = an;
        case (m_mode)
            0: if (acc) begin
                if (legal(an)) model_load(an);
                else begin
                    m_mode  = 1;
                    m_age   = 0;
                    m_valid = 1'b0;
                end
            end
            1: if (legal(an)) begin
                m_mode = 0;
                model_load(an);
            end else begin
                m_age++;
                if (m_age == FC + 1) begin
                    m_mode  = 2;
                    m_fault = 1'b1;
                    m_code  = 2'b00;
                    m_valid = 1'b0;
                    m_pump  = 1'b0;
                end
            end
            default: if (clr && legal(an)) begin
                m_mode  = 0;
                m_fault = 1'b0;
                model_load(an);
            end
        endcase
    endtask

    // Drive inputs at a falling edge, advance one rising edge, return at the
    // next falling edge where outputs are sampled.
    task automatic step(input logic [2:0] s, input logic clr);
        {SensorHigh, SensorMid, SensorLow} = s;
        ClearFault = clr;
        @(posedge clk);
        if (rst_n) model_edge(s, clr);
        @(negedge clk);
    endtask

    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [4:0] want;
        model_reset();
        repeat (2) @(negedge clk);
        if (dut_vec() !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_values got=%b exp=%b", dut_vec(), 5'b0);
        end
        n_cmp++;
        rst_n = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            step(3'b000, 1'b0);
            want = (k >= DC + 2) ? 5'b00101 : 5'b00000;
            if (dut_vec() !== want) begin
                n_bad++;
                $display("FAIL reset_first_valid edge=%0d got=%b exp=%b", k, dut_vec(), want);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_model edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_levels();
        logic [2:0] seq[4]  = '{3'b001, 3'b011, 3'b111, 3'b011};
        logic [1:0] cseq[4] = '{2'b10, 2'b01, 2'b11, 2'b01};
        logic       pseq[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] prev;
        prev = 2'b00;
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 20; k++) begin
                step(seq[l], 1'b0);
                if (dut_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL levels_model lvl=%0d edge=%0d got=%b exp=%b", l, k, dut_vec(), exp_vec());
                end
                n_cmp++;
                if (k == DC + 1 && {Bit1, Bit0} !== prev) begin
                    n_bad++;
                    $display("FAIL levels_early lvl=%0d got=%b exp=%b", l, {Bit1, Bit0}, prev);
                end
                if (k == DC + 1) n_cmp++;
                if (k == DC + 2 && {Bit1, Bit0, Valid} !== {cseq[l], 1'b1}) begin
                    n_bad++;
                    $display("FAIL levels_latency lvl=%0d got=%b exp=%b", l, {Bit1, Bit0, Valid}, {cseq[l], 1'b1});
                end
                if (k == DC + 2) n_cmp++;
            end
            if (dut_vec() !== {cseq[l], 1'b1, 1'b0, pseq[l]}) begin
                n_bad++;
                $display("FAIL levels_hold lvl=%0d got=%b exp=%b", l, dut_vec(), {cseq[l], 1'b1, 1'b0, pseq[l]});
            end
            n_cmp++;
            prev = cseq[l];
        end
    endtask

    task automatic test_bounce();
        logic [2:0] pat;
        for (int k = 0; k < 12; k++) step(3'b001, 1'b0);
        for (int k = 0; k < 18; k++) begin
            pat = (k < 3 && (k % 2) == 0) ? 3'b011 : 3'b001;
            step(pat, 1'b0);
            if ({Bit1, Bit0, Valid} !== 3'b101) begin
                n_bad++;
                $display("FAIL bounce_hold edge=%0d got=%b exp=%b", k, {Bit1, Bit0, Valid}, 3'b101);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL bounce_model edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_fault();
        logic [3:0] want;
        for (int k = 0; k < 20; k++) begin
            step(3'b101, 1'b0);
            want = (k >= DC + 2 + FC + 1) ? 4'b0001 : {2'b10, (k < DC + 2), 1'b0};
            if ({Bit1, Bit0, Valid, Fault} !== want) begin
                n_bad++;
                $display("FAIL fault_timing edge=%0d got=%b exp=%b", k, {Bit1, Bit0, Valid, Fault}, want);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fault_model edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
        for (int k = 0; k < 3; k++) begin
            step(3'b101, 1'b1);
            if (dut_vec() !== 5'b00010) begin
                n_bad++;
                $display("FAIL fault_clear_illegal edge=%0d got=%b exp=%b", k, dut_vec(), 5'b00010);
            end
            n_cmp++;
        end
        for (int k = 0; k < DC + 3; k++) begin
            step(3'b000, 1'b0);
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fault_wait_model edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
        step(3'b000, 1'b1);
        if (dut_vec() !== 5'b00101) begin
            n_bad++;
            $display("FAIL fault_clear got=%b exp=%b", dut_vec(), 5'b00101);
        end
        n_cmp++;
        for (int k = 0; k < 4; k++) begin
            step(3'b000, 1'b0);
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fault_after_model edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_recover();
        logic [2:0] bad[4] = '{3'b010, 3'b100, 3'b101, 3'b110};
        int         nacc;
        logic [2:0] ill;
        for (int r = 0; r < 5; r++) begin
            nacc = (r == 0) ? 5 : int'($urandom_range(4, 1));
            ill  = (r == 0) ? 3'b101 : bad[$urandom_range(3, 0)];
            for (int k = 0; k < 4 + nacc + 16; k++) begin
                step((k < 4 + nacc) ? ill : 3'b011, 1'b0);
                if (Fault !== 1'b0) begin
                    n_bad++;
                    $display("FAIL recover_no_fault run=%0d edge=%0d got=%b exp=%b", r, k, Fault, 1'b0);
                end
                n_cmp++;
                if (dut_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL recover_model run=%0d edge=%0d got=%b exp=%b", r, k, dut_vec(), exp_vec());
                end
                n_cmp++;
            end
            if ({Bit1, Bit0, Valid} !== 3'b011) begin
                n_bad++;
                $display("FAIL recover_level run=%0d got=%b exp=%b", r, {Bit1, Bit0, Valid}, 3'b011);
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        logic [2:0] s;
        int unsigned len;
        logic        clr;
        for (int seg = 0; seg < 40; seg++) begin
            s   = 3'($urandom_range(7, 0));
            len = $urandom_range(14, 1);
            for (int unsigned k = 0; k < len; k++) begin
                clr = ($urandom_range(7, 0) == 0);
                step(s, clr);
                if (dut_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random_model seg=%0d edge=%0d in=%b got=%b exp=%b", seg, k, s, dut_vec(), exp_vec());
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] want;
        for (int k = 0; k < 12; k++) step(3'b001, 1'b1);
        for (int k = 0; k < 3; k++) step(3'b111, 1'b0);
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL areset_pre_model got=%b exp=%b", dut_vec(), exp_vec());
        end
        n_cmp++;
        assert_reset();
        if (dut_vec() !== 5'b0) begin
            n_bad++;
            $display("FAIL areset_debounce got=%b exp=%b", dut_vec(), 5'b0);
        end
        n_cmp++;
        release_reset();
        for (int k = 0; k <= DC + 3; k++) begin
            step(3'b011, 1'b0);
            want = (k >= DC + 2) ? 5'b01100 : 5'b00000;
            if (dut_vec() !== want) begin
                n_bad++;
                $display("FAIL areset_restart edge=%0d got=%b exp=%b", k, dut_vec(), want);
            end
            n_cmp++;
        end
        for (int k = 0; k < 20; k++) step(3'b110, 1'b0);
        if (dut_vec() !== 5'b00010) begin
            n_bad++;
            $display("FAIL areset_in_fault got=%b exp=%b", dut_vec(), 5'b00010);
        end
        n_cmp++;
        assert_reset();
        if (dut_vec() !== 5'b0) begin
            n_bad++;
            $display("FAIL areset_fault got=%b exp=%b", dut_vec(), 5'b0);
        end
        n_cmp++;
        release_reset();
        for (int k = 0; k <= DC + 3; k++) begin
            step(3'b001, 1'b0);
            want = (k >= DC + 2) ? 5'b10100 : 5'b00000;
            if (dut_vec() !== want) begin
                n_bad++;
                $display("FAIL areset_normal edge=%0d got=%b exp=%b", k, dut_vec(), want);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL areset_model edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_levels();
        test_bounce();
        test_fault();
        test_recover();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
